// File: rtl/peripheral_bridge_wb_waitstate_if.sv
// Wishbone classic bus bundle used on both sides of the wait-state bridge.
//   master modport : drives adr/dat_w/sel/we/cyc/stb/cti/bte, receives dat_r/ack/err/rty
//   slave  modport : receives adr/dat_w/sel/we/cyc/stb/cti/bte, drives dat_r/ack/err/rty
interface peripheral_bridge_wb_waitstate_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic [AW-1:0] adr;
  logic [DW-1:0] dat_w;
  logic [DW-1:0] dat_r;
  logic [3:0]    sel;
  logic          we;
  logic          cyc;
  logic          stb;
  logic [2:0]    cti;
  logic [1:0]    bte;
  logic          ack;
  logic          err;
  logic          rty;

  modport master (
    output adr, dat_w, sel, we, cyc, stb, cti, bte,
    input  dat_r, ack, err, rty
  );

  modport slave (
    input  adr, dat_w, sel, we, cyc, stb, cti, bte,
    output dat_r, ack, err, rty
  );
endinterface

// File: rtl/peripheral_bridge_wb_waitstate.sv
// Wishbone wait-state bridge: accepts one upstream classic access, waits a
// programmable number of cycles, performs one downstream classic access and
// returns its termination (ack/err/rty) upstream for one cycle. A downstream
// access that never terminates is ended after TIMEOUT cycles with an error.
//
// Ports
//   wb_clk_i : clock, rising edge
//   wb_rst_i : synchronous active-high reset
//   wbs      : upstream side (bridge is the slave), cti/bte inputs ignored
//   wbm      : downstream side (bridge is the master), cti/bte tied to 0
//
// Build option
//   PERIPHERAL_BRIDGE_WB_RANDOM_STALL_EN : adds a 16-bit Fibonacci LFSR
//   (taps 16,14,13,11) so each delay is WAIT_CYCLES + lfsr[1:0].
//
// state | meaning
// IDLE  | waiting for wbs cyc & stb, latches the request
// WAIT  | counting down the inserted delay
// REQ   | downstream cyc/stb asserted, waiting for termination or timeout
// RESP  | one-cycle upstream ack/err/rty with captured data
module peripheral_bridge_wb_waitstate #(
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned TIMEOUT     = 64,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input logic                              wb_clk_i,
  input logic                              wb_rst_i,
  peripheral_bridge_wb_waitstate_if.slave  wbs,
  peripheral_bridge_wb_waitstate_if.master wbm
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_REQ  = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  localparam logic [4:0] WAIT_C = 5'(WAIT_CYCLES);
  localparam logic [7:0] TMO_C  = 8'(TIMEOUT);

  logic [1:0]    state_q, state_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [7:0]    tmo_q, tmo_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [DW-1:0] wdat_q, wdat_d;
  logic [3:0]    sel_q, sel_d;
  logic          we_q, we_d;
  logic          cyc_q, cyc_d;
  logic [DW-1:0] rdat_q, rdat_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic          rty_q, rty_d;
  logic [4:0]    delay;
  logic          req_accept;

  assign req_accept = (state_q == ST_IDLE) && wbs.cyc && wbs.stb;

`ifdef PERIPHERAL_BRIDGE_WB_RANDOM_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic        lfsr_fb;
  logic        unused_ok;

  assign lfsr_fb   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  // Delay uses the LFSR value present at acceptance; the step happens on the same edge.
  assign delay     = WAIT_C + {3'b000, lfsr_q[1:0]};
  assign lfsr_d    = req_accept ? {lfsr_q[14:0], lfsr_fb} : lfsr_q;
  assign unused_ok = ^{wbs.cti, wbs.bte};

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) lfsr_q <= SEED;
    else          lfsr_q <= lfsr_d;
  end
`else
  logic unused_ok;

  assign delay     = WAIT_C;
  assign unused_ok = ^{wbs.cti, wbs.bte, SEED};
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    cyc_d   = cyc_q;
    rdat_d  = rdat_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rty_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_accept) begin
          adr_d  = wbs.adr;
          wdat_d = wbs.dat_w;
          sel_d  = wbs.sel;
          we_d   = wbs.we;
          cnt_d  = delay;
          if (delay == 5'd0) begin
            state_d = ST_REQ;
            cyc_d   = 1'b1;
            tmo_d   = TMO_C;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!wbs.cyc) begin
          state_d = ST_IDLE;
          cnt_d   = 5'd0;
        end else begin
          cnt_d = cnt_q - 5'd1;
          if (cnt_q == 5'd1) begin
            state_d = ST_REQ;
            cyc_d   = 1'b1;
            tmo_d   = TMO_C;
          end
        end
      end
      ST_REQ: begin
        // Upstream abort wins over a termination arriving in the same cycle.
        if (!wbs.cyc) begin
          state_d = ST_IDLE;
          cyc_d   = 1'b0;
          tmo_d   = 8'd0;
        end else if (wbm.err || wbm.rty || wbm.ack) begin
          state_d = ST_RESP;
          cyc_d   = 1'b0;
          tmo_d   = 8'd0;
          rdat_d  = wbm.dat_r;
          err_d   = wbm.err;
          rty_d   = !wbm.err && wbm.rty;
          ack_d   = !wbm.err && !wbm.rty;
        end else if (tmo_q == 8'd1) begin
          state_d = ST_RESP;
          cyc_d   = 1'b0;
          tmo_d   = 8'd0;
          rdat_d  = '0;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q - 8'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 5'd0;
      tmo_q   <= 8'd0;
      adr_q   <= '0;
      wdat_q  <= '0;
      sel_q   <= 4'd0;
      we_q    <= 1'b0;
      cyc_q   <= 1'b0;
      rdat_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rty_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      cyc_q   <= cyc_d;
      rdat_q  <= rdat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rty_q   <= rty_d;
    end
  end

  assign wbm.adr   = adr_q;
  assign wbm.dat_w = wdat_q;
  assign wbm.sel   = sel_q;
  assign wbm.we    = we_q;
  assign wbm.cyc   = cyc_q;
  assign wbm.stb   = cyc_q;
  assign wbm.cti   = 3'b000;
  assign wbm.bte   = 2'b00;

  assign wbs.dat_r = rdat_q;
  assign wbs.ack   = ack_q;
  assign wbs.err   = err_q;
  assign wbs.rty   = rty_q;

endmodule

// File: tb/tb_peripheral_bridge_wb_waitstate.sv
// Self-checking bench for peripheral_bridge_wb_waitstate.
// Instance 0: WAIT_CYCLES=2, TIMEOUT=8 with a programmable memory slave.
// Instance 1: WAIT_CYCLES=0 with an always-acknowledging slave.
module tb_peripheral_bridge_wb_waitstate;

  localparam int W0   = 2;
  localparam int TMO0 = 8;
  localparam int W1   = 0;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  peripheral_bridge_wb_waitstate_if #(.AW(32), .DW(32)) up0 ();
  peripheral_bridge_wb_waitstate_if #(.AW(32), .DW(32)) dn0 ();
  peripheral_bridge_wb_waitstate_if #(.AW(32), .DW(32)) up1 ();
  peripheral_bridge_wb_waitstate_if #(.AW(32), .DW(32)) dn1 ();

  peripheral_bridge_wb_waitstate #(
    .AW(32), .DW(32), .WAIT_CYCLES(W0), .TIMEOUT(TMO0), .SEED(SEED)
  ) u_dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs(up0.slave), .wbm(dn0.master)
  );

  peripheral_bridge_wb_waitstate #(
    .AW(32), .DW(32), .WAIT_CYCLES(W1), .TIMEOUT(64), .SEED(SEED)
  ) u_dut_w0 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs(up1.slave), .wbm(dn1.master)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // ---------------- slave model for instance 0 ----------------
  // kind: 0 ack, 1 err+ack together, 2 rty+ack together, 3 never terminates
  int          slv_lat  = 1;
  int          slv_kind = 0;
  int          slv_cnt  = 0;
  logic [31:0] mem0 [16] = '{default: 32'h0};
  logic        term0;
  logic        cyc_prev0 = 1'b0;
  int          acc_cnt0  = 0;
  int          cyc_hi0   = 0;
  int          resp_cnt0 = 0;

  assign term0     = dn0.cyc && dn0.stb && (slv_kind != 3) && (slv_cnt + 1 >= slv_lat);
  assign dn0.ack   = term0 && (slv_kind == 0 || slv_kind == 1 || slv_kind == 2);
  assign dn0.err   = term0 && (slv_kind == 1);
  assign dn0.rty   = term0 && (slv_kind == 2);
  assign dn0.dat_r = mem0[dn0.adr[5:2]];

  always @(posedge clk) begin
    cyc_prev0 <= dn0.cyc;
    if (dn0.cyc && !cyc_prev0) acc_cnt0 <= acc_cnt0 + 1;
    if (dn0.cyc) cyc_hi0 <= cyc_hi0 + 1;
    if (up0.ack || up0.err || up0.rty) resp_cnt0 <= resp_cnt0 + 1;
    if (dn0.cyc && dn0.stb && !term0) slv_cnt <= slv_cnt + 1;
    else                              slv_cnt <= 0;
    if (term0 && slv_kind == 0 && dn0.we)
      for (int b = 0; b < 4; b++)
        if (dn0.sel[b]) mem0[dn0.adr[5:2]][8*b +: 8] <= dn0.dat_w[8*b +: 8];
  end

  // ---------------- slave for instance 1 ----------------
  assign dn1.ack   = dn1.cyc && dn1.stb;
  assign dn1.err   = 1'b0;
  assign dn1.rty   = 1'b0;
  assign dn1.dat_r = ~dn1.adr;

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [int];
  logic [15:0] lfsr_m0 = SEED;
  logic [15:0] lfsr_m1 = SEED;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    int v, fb;
    v  = int'(s);
    fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
    return 16'(((v << 1) | fb) & 16'hFFFF);
  endfunction

  function automatic int take_delay0();
    int d;
`ifdef PERIPHERAL_BRIDGE_WB_RANDOM_STALL_EN
    d = W0 + (int'(lfsr_m0) % 4);
    lfsr_m0 = lfsr_step(lfsr_m0);
`else
    d = W0;
`endif
    return d;
  endfunction

  function automatic int take_delay1();
    int d;
`ifdef PERIPHERAL_BRIDGE_WB_RANDOM_STALL_EN
    d = W1 + (int'(lfsr_m1) % 4);
    lfsr_m1 = lfsr_step(lfsr_m1);
`else
    d = W1;
`endif
    return d;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] adr);
    int idx;
    idx = int'(adr[5:2]);
    return ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
  endfunction

  function automatic void ref_wr(input logic [31:0] adr, input logic [31:0] dat,
                                 input logic [3:0] sel);
    logic [31:0] w, m;
    int idx;
    idx = int'(adr[5:2]);
    w   = ref_rd(adr);
    for (int b = 0; b < 4; b++)
      if (sel[b]) begin
        m = 32'hFF << (8 * b);
        w = (w & ~m) | (dat & m);
      end
    ref_mem[idx] = w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One upstream transaction on instance 0. Called just after a negedge with the
  // DUT idle; returns just after the negedge following the response cycle.
  task automatic xfer0(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input int lat, input int kind,
                       input logic keep);
    int dly, n, exp_lat, acc_b, hi_b, meas, l_eff;
    logic got;
    logic [31:0] exp_dat;
    logic [2:0] exp_rsp;
    dly   = take_delay0();
    acc_b = acc_cnt0;
    hi_b  = cyc_hi0;
    slv_lat  = lat;
    slv_kind = kind;
    exp_dat  = (kind == 3) ? 32'h0 : ref_rd(adr);
    case (kind)
      0:       exp_rsp = 3'b100;
      2:       exp_rsp = 3'b001;
      default: exp_rsp = 3'b010;
    endcase
    l_eff   = (kind == 3) ? TMO0 : lat;
    exp_lat = 1 + dly + l_eff + 1;
    up0.cyc = 1'b1; up0.stb = 1'b1; up0.we = we;
    up0.adr = adr; up0.dat_w = dat; up0.sel = sel;
    got = 1'b0;
    n   = 0;
    while (!got && n < 200) begin
      @(negedge clk);
      n++;
      if (up0.ack || up0.err || up0.rty) got = 1'b1;
    end
    chk("resp_seen", 32'(got), 32'd1);
    if (got) begin
      chk("latency", 32'(n + 1), 32'(exp_lat));
      meas = n + 1 - 2 - l_eff;
      chk("delay_range", 32'(meas >= W0 && meas <= W0 + 3), 32'd1);
      chk("resp_type", 32'({up0.ack, up0.err, up0.rty}), 32'(exp_rsp));
      chk("resp_data", up0.dat_r, exp_dat);
      chk("one_access", 32'(acc_cnt0 - acc_b), 32'd1);
      if (kind == 3) chk("tmo_req_cycles", 32'(cyc_hi0 - hi_b), 32'(TMO0));
    end
    if (kind == 0 && we) ref_wr(adr, dat, sel);
    if (!keep) begin
      up0.cyc = 1'b0;
      up0.stb = 1'b0;
    end
    @(negedge clk);
    chk("pulse_one_cycle", 32'({up0.ack, up0.err, up0.rty}), 32'd0);
    chk("dat_hold", up0.dat_r, exp_dat);
  endtask

  task automatic wait_dn0_cyc(output logic seen);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (dn0.cyc) seen = 1'b1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d1, n, rc, hb, ab;
    logic seen;
    up0.cyc = 0; up0.stb = 0; up0.we = 0; up0.adr = 0; up0.dat_w = 0; up0.sel = 0;
    up0.cti = 3'b111; up0.bte = 2'b11;
    up1.cyc = 0; up1.stb = 0; up1.we = 0; up1.adr = 0; up1.dat_w = 0; up1.sel = 0;
    up1.cti = 3'b010; up1.bte = 2'b01;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_cyc_stb_we", 32'({dn0.cyc, dn0.stb, dn0.we}), 32'd0);
    chk("rst_adr", dn0.adr, 32'd0);
    chk("rst_dat_w", dn0.dat_w, 32'd0);
    chk("rst_sel", 32'(dn0.sel), 32'd0);
    chk("rst_resp", 32'({up0.ack, up0.err, up0.rty}), 32'd0);
    chk("rst_dat_r", up0.dat_r, 32'd0);
    chk("rst_cti_bte", 32'({dn0.cti, dn0.bte}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // write then read back with a one-cycle slave
    xfer0(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1, 0, 1'b0);
    xfer0(1'b0, 32'h10, 32'h0, 4'hF, 1, 0, 1'b0);
    chk("readback", up0.dat_r, 32'hDEADBEEF);

    // err and ack together -> err only; rty and ack together -> rty only
    xfer0(1'b0, 32'h10, 32'h0, 4'hF, 2, 1, 1'b0);
    xfer0(1'b0, 32'h14, 32'h0, 4'hF, 1, 2, 1'b0);

    // slave never terminates -> timeout error with zero data
    xfer0(1'b0, 32'h10, 32'h0, 4'hF, 1, 3, 1'b0);

    // abort during WAIT: no downstream access, no response
    void'(take_delay0());
    hb = cyc_hi0; rc = resp_cnt0;
    up0.cyc = 1'b1; up0.stb = 1'b1; up0.we = 1'b1; up0.adr = 32'h20; up0.dat_w = 32'h5A5A5A5A;
    up0.sel = 4'hF;
    @(negedge clk);
    up0.cyc = 1'b0; up0.stb = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort_wait_no_cyc", 32'(cyc_hi0 - hb), 32'd0);
    chk("abort_wait_no_resp", 32'(resp_cnt0 - rc), 32'd0);
    xfer0(1'b0, 32'h10, 32'h0, 4'hF, 1, 0, 1'b0);

    // abort during REQ: cyc drops next cycle, response discarded
    void'(take_delay0());
    rc = resp_cnt0;
    slv_kind = 3;
    up0.cyc = 1'b1; up0.stb = 1'b1; up0.we = 1'b0; up0.adr = 32'h10;
    wait_dn0_cyc(seen);
    chk("abort_req_started", 32'(seen), 32'd1);
    up0.cyc = 1'b0; up0.stb = 1'b0;
    @(negedge clk);
    chk("abort_req_cyc_drop", 32'(dn0.cyc), 32'd0);
    repeat (12) @(negedge clk);
    chk("abort_req_no_resp", 32'(resp_cnt0 - rc), 32'd0);

    // back-to-back with the request held through the response cycle
    xfer0(1'b1, 32'h24, 32'h01234567, 4'h3, 1, 0, 1'b1);
    xfer0(1'b0, 32'h24, 32'h0, 4'hF, 3, 0, 1'b0);

    // eight reads: delay tracks the model
    for (int i = 0; i < 8; i++) xfer0(1'b0, 32'h10, 32'h0, 4'hF, 1, 0, 1'b0);

    // randomized traffic
    for (int i = 0; i < 30; i++) begin
      int r, kind;
      r    = int'($urandom_range(0, 9));
      kind = (r < 6) ? 0 : (r - 6);
      xfer0(1'($urandom_range(0, 1)), {26'd0, 4'($urandom_range(0, 15)), 2'b00}, $urandom,
            4'($urandom_range(0, 15)), int'($urandom_range(1, 4)), kind,
            (i < 29) && ($urandom_range(0, 3) == 0));
    end

    // reset in the middle of REQ
    void'(take_delay0());
    rc = resp_cnt0;
    slv_kind = 3;
    up0.cyc = 1'b1; up0.stb = 1'b1; up0.we = 1'b1; up0.adr = 32'h3C;
    up0.dat_w = 32'hCAFEF00D; up0.sel = 4'hF;
    wait_dn0_cyc(seen);
    chk("rst_req_started", 32'(seen), 32'd1);
    rst = 1'b1; up0.cyc = 1'b0; up0.stb = 1'b0;
    @(negedge clk);
    chk("midrst_cyc_stb_we", 32'({dn0.cyc, dn0.stb, dn0.we}), 32'd0);
    chk("midrst_adr_dat", dn0.adr | dn0.dat_w, 32'd0);
    chk("midrst_sel_resp", 32'({dn0.sel, up0.ack, up0.err, up0.rty}), 32'd0);
    chk("midrst_dat_r", up0.dat_r, 32'd0);
    rst = 1'b0;
    lfsr_m0 = SEED;
    lfsr_m1 = SEED;
    repeat (4) @(negedge clk);
    chk("midrst_no_resp", 32'(resp_cnt0 - rc), 32'd0);
    xfer0(1'b0, 32'h10, 32'h0, 4'hF, 1, 0, 1'b0);

    // zero-wait instance: stb on the cycle after acceptance (plus any random stall)
    d1 = take_delay1();
    up1.cyc = 1'b1; up1.stb = 1'b1; up1.we = 1'b0; up1.adr = 32'h0000_0040; up1.sel = 4'hF;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 30) begin
      @(negedge clk);
      n++;
      if (dn1.stb) seen = 1'b1;
    end
    chk("w0_stb_seen", 32'(seen), 32'd1);
    chk("w0_stb_cycle", 32'(n), 32'(d1 + 1));
    chk("w0_cti_bte", 32'({dn1.cti, dn1.bte}), 32'd0);
    seen = 1'b0;
    ab = 0;
    while (!seen && ab < 30) begin
      @(negedge clk);
      ab++;
      if (up1.ack) seen = 1'b1;
    end
    chk("w0_ack_seen", 32'(seen), 32'd1);
    chk("w0_data", up1.dat_r, ~32'h0000_0040);
    up1.cyc = 1'b0; up1.stb = 1'b0;
    @(negedge clk);
    chk("w0_ack_pulse", 32'(up1.ack), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
